// File: rtl/uart_frame_ctrl_pkg.sv
// Shared state encoding, error codes and default header for the UART frame controller.
package uart_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StHold,
    StCheck
  } state_e;

  localparam logic [1:0] ErrOverrun  = 2'b00;
  localparam logic [1:0] ErrBadLen   = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;
  localparam logic [1:0] ErrChecksum = 2'b11;

  localparam logic [7:0] DefaultHeader = 8'hAA;

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte timeout counter: clears on clr, advances while run, flags expiry at TIMEOUT_CYC-1.
module frame_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned TO_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TO_W-1:0] Limit = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q;

  // Saturates at the limit so a frozen count never wraps back below it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = run && (cnt_q == Limit);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser for the UART receiver: [HEADER][LEN][payload][CHK] with payload forwarded
// over a valid/ready stream and per-frame OK/error pulses.
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter logic [7:0]  HEADER      = DefaultHeader,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned TO_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       rx_enable,
  output logic [7:0] pay_data,
  output logic       pay_valid,
  input  logic       pay_ready,
  output logic       pay_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] pay_data_q, pay_data_d;
  logic       pay_valid_q, pay_valid_d;
  logic       pay_last_q, pay_last_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       rx_enable_q, rx_enable_d;
  logic       busy_q, busy_d;

  logic to_clr, to_run, to_expired;

  assign to_run = (state_q == StLen) || (state_q == StPayload) || (state_q == StCheck);

  frame_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr),
    .run    (to_run),
    .expired(to_expired)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    pay_data_d  = pay_data_q;
    pay_valid_d = pay_valid_q;
    pay_last_d  = pay_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    to_clr      = rx_done;

    unique case (state_q)
      StIdle: begin
        if (rx_done && (rx_data == HEADER)) begin
          state_d = StLen;
        end
      end
      StLen: begin
        if (rx_done) begin
          if ((rx_data == 8'd0) || (rx_data > MaxLenB)) begin
            frame_err_d = 1'b1;
            err_code_d  = ErrBadLen;
            state_d     = StIdle;
          end else begin
            len_d   = rx_data;
            chk_d   = rx_data;
            cnt_d   = 8'd0;
            state_d = StPayload;
          end
        end else if (to_expired) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrTimeout;
          state_d     = StIdle;
        end
      end
      StPayload: begin
        if (rx_done) begin
          pay_data_d  = rx_data;
          pay_valid_d = 1'b1;
          pay_last_d  = (cnt_q == len_q - 8'd1);
          chk_d       = chk_q ^ rx_data;
          cnt_d       = cnt_q + 8'd1;
          state_d     = StHold;
        end else if (to_expired) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrTimeout;
          state_d     = StIdle;
        end
      end
      StHold: begin
        // A byte arriving here was already in flight when the enable dropped.
        if (rx_done) begin
          pay_valid_d = 1'b0;
          pay_last_d  = 1'b0;
          frame_err_d = 1'b1;
          err_code_d  = ErrOverrun;
          state_d     = StIdle;
        end else if (pay_valid_q && pay_ready) begin
          pay_valid_d = 1'b0;
          pay_last_d  = 1'b0;
          to_clr      = 1'b1;
          state_d     = pay_last_q ? StCheck : StPayload;
        end
      end
      StCheck: begin
        if (rx_done) begin
          if (rx_data == chk_q) begin
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ErrChecksum;
          end
          state_d = StIdle;
        end else if (to_expired) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrTimeout;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    rx_enable_d = (state_d != StHold);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= 8'd0;
      cnt_q       <= 8'd0;
      chk_q       <= 8'd0;
      pay_data_q  <= 8'd0;
      pay_valid_q <= 1'b0;
      pay_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      rx_enable_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
      pay_last_q  <= pay_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      rx_enable_q <= rx_enable_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_enable = rx_enable_q;
  assign pay_data  = pay_data_q;
  assign pay_valid = pay_valid_q;
  assign pay_last  = pay_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: random frames against a frame-level model plus directed corners.
module tb_uart_frame_ctrl;

  localparam int unsigned MaxLen     = 16;
  localparam int unsigned TimeoutCyc = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_enable;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       pay_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .HEADER     (8'hAA),
    .MAX_LEN    (MaxLen),
    .TIMEOUT_CYC(TimeoutCyc),
    .TO_W       (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_enable(rx_enable),
    .pay_data (pay_data),
    .pay_valid(pay_valid),
    .pay_ready(pay_ready),
    .pay_last (pay_last),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  // Observer: logs accepted payload bytes and result pulses, sampled mid-cycle.
  int         cyc;
  int         pay_wr;
  int         ok_seen;
  int         err_seen;
  int         both_seen;
  int         err_cyc;
  logic [1:0] err_code_seen;
  logic [7:0] pay_log      [0:4095];
  logic       pay_last_log [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pay_valid && pay_ready) begin
      pay_log[pay_wr[11:0]]      <= pay_data;
      pay_last_log[pay_wr[11:0]] <= pay_last;
      pay_wr                     <= pay_wr + 1;
    end
    if (frame_ok) ok_seen <= ok_seen + 1;
    if (frame_err) begin
      err_seen      <= err_seen + 1;
      err_code_seen <= err_code;
      err_cyc       <= cyc;
    end
    if (frame_ok && frame_err) both_seen <= both_seen + 1;
  end

  int checks;
  int errors;
  int ready_mode;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ready(input int mode);
    ready_mode = mode;
    pay_ready  = (mode != 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       pay_ready = 1'b1;
      1:       pay_ready = 1'($urandom_range(0, 1));
      default: pay_ready = 1'b0;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Byte is sampled by the DUT on the next rising edge.
  task automatic pulse(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Well-behaved receiver: only starts a byte while enabled.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    idle($urandom_range(0, 20));
    while (!rx_enable && n < 1000) begin
      tick();
      n++;
    end
    chk("enable_wait", int'(rx_enable), 1);
    pulse(b);
  endtask

  // Frame-level model: valid LEN forwards every payload byte, last flagged on the final one;
  // checksum is XOR of LEN and payload.
  task automatic run_frame(input int len, input bit good_chk, input int junk);
    logic [7:0] pl [0:255];
    logic [7:0] c;
    logic [7:0] b;
    int         base, ok0, err0, exp_pay;
    bit         len_ok, exp_ok;
    for (int i = 0; i < junk; i++) begin
      b = 8'($urandom);
      if (b == 8'hAA) b = 8'h55;
      send(b);
    end
    base   = pay_wr;
    ok0    = ok_seen;
    err0   = err_seen;
    len_ok = (len >= 1) && (len <= int'(MaxLen));
    exp_ok = len_ok && good_chk;
    send(8'hAA);
    send(8'(len));
    c = 8'(len);
    if (len_ok) begin
      for (int i = 0; i < len; i++) begin
        pl[i] = 8'($urandom);
        c     = c ^ pl[i];
        send(pl[i]);
      end
      send(good_chk ? c : (c ^ 8'($urandom_range(1, 255))));
    end
    idle(3);
    exp_pay = len_ok ? len : 0;
    chk("pay_count", pay_wr - base, exp_pay);
    for (int i = 0; i < exp_pay; i++) begin
      chk("pay_data", int'(pay_log[12'(base + i)]), int'(pl[i]));
      chk("pay_last", int'(pay_last_log[12'(base + i)]), int'(i == len - 1));
    end
    chk("ok_pulses", ok_seen - ok0, int'(exp_ok));
    chk("err_pulses", err_seen - err0, int'(!exp_ok));
    if (!exp_ok) chk("err_code", int'(err_code_seen), len_ok ? 3 : 1);
    chk("busy_after", int'(busy), 0);
  endtask

  initial begin
    int ok0, err0, wr0, t0;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    rx_done    = 1'b0;
    rx_data    = 8'h00;
    ready_mode = 0;
    pay_ready  = 1'b1;
    #23;
    chk("rst_rx_enable", int'(rx_enable), 0);
    chk("rst_pay_valid", int'(pay_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_ok", int'(frame_ok), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_err_code", int'(err_code), 0);
    rst = 1'b0;
    #1;
    chk("rel_rx_enable_low", int'(rx_enable), 0);
    tick();
    chk("rel_rx_enable_high", int'(rx_enable), 1);

    // Directed length errors, then random traffic.
    run_frame(0, 1'b1, 0);
    run_frame(17, 1'b1, 0);
    for (int f = 0; f < 30; f++) begin
      int r, len;
      r = $urandom_range(0, 9);
      if (r == 0) len = 0;
      else if (r == 1) len = $urandom_range(MaxLen + 1, 255);
      else len = $urandom_range(1, MaxLen);
      set_ready($urandom_range(0, 1));
      run_frame(len, $urandom_range(0, 3) != 0, $urandom_range(0, 2));
    end
    set_ready(0);

    // Timeout: counter restarts on the edge that leaves HOLD, one edge after the byte.
    err0 = err_seen;
    pulse(8'hAA);
    pulse(8'h04);
    pulse(8'h01);
    t0 = cyc;
    idle(300);
    chk("to_err_pulses", err_seen - err0, 1);
    chk("to_err_code", int'(err_code_seen), 2);
    chk("to_latency", err_cyc - t0, int'(TimeoutCyc) + 1);

    // Byte landing exactly on the expiry edge is processed instead of timing out.
    ok0  = ok_seen;
    err0 = err_seen;
    pulse(8'hAA);
    idle(TimeoutCyc - 1);
    pulse(8'h01);
    pulse(8'h3C);
    idle(2);
    pulse(8'h3D);
    idle(3);
    chk("edge_ok", ok_seen - ok0, 1);
    chk("edge_no_err", err_seen - err0, 0);

    // One cycle later the timeout fires first.
    err0 = err_seen;
    pulse(8'hAA);
    idle(TimeoutCyc);
    idle(2);
    chk("late_err", err_seen - err0, 1);
    chk("late_code", int'(err_code_seen), 2);
    chk("late_busy", int'(busy), 0);

    // Long stall in HOLD: enable low, no timeout; then overrun on an in-flight byte.
    err0 = err_seen;
    wr0  = pay_wr;
    set_ready(2);
    pulse(8'hAA);
    pulse(8'h02);
    pulse(8'h10);
    idle(100);
    chk("stall_rx_enable", int'(rx_enable), 0);
    chk("stall_pay_valid", int'(pay_valid), 1);
    chk("stall_pay_data", int'(pay_data), 8'h10);
    chk("stall_no_err", err_seen - err0, 0);
    set_ready(0);
    tick();
    chk("resume_rx_enable", int'(rx_enable), 1);
    chk("resume_accepted", pay_wr - wr0, 1);
    set_ready(2);
    pulse(8'h20);
    idle(2);
    pulse(8'h33);
    idle(2);
    chk("ovr_err", err_seen - err0, 1);
    chk("ovr_code", int'(err_code_seen), 0);
    chk("ovr_pay_valid", int'(pay_valid), 0);
    chk("ovr_busy", int'(busy), 0);
    set_ready(0);

    // Overrun coinciding with the handshake: the byte still counts as accepted.
    err0 = err_seen;
    wr0  = pay_wr;
    pulse(8'hAA);
    pulse(8'h02);
    pulse(8'h77);
    pulse(8'h88);
    idle(2);
    chk("ovr_hs_accepted", pay_wr - wr0, 1);
    chk("ovr_hs_err", err_seen - err0, 1);
    chk("ovr_hs_code", int'(err_code_seen), 0);

    // Reset mid-payload clears outputs immediately, then a clean frame completes.
    ok0  = ok_seen;
    err0 = err_seen;
    set_ready(2);
    pulse(8'hAA);
    pulse(8'h05);
    pulse(8'h42);
    rst = 1'b1;
    #1;
    chk("mid_rst_pay_valid", int'(pay_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rx_enable", int'(rx_enable), 0);
    set_ready(0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_no_pulse", (ok_seen - ok0) + (err_seen - err0), 0);
    run_frame(4, 1'b1, 1);

    chk("never_ok_and_err", both_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
